regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameters SHALL be: DATAW, default 32, register data width; NUM_REGS, default 32, register count; ADDRW, default $clog2(NUM_REGS), register index width.
REQ-002 Ports SHALL be:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  scoreboard accepts; transfer when issue_valid && issue_ready.
- issue_rs1, issue_rs2  in  ADDRW  source indices.
- issue_use_rs1, issue_use_rs2  in  1  source actually read.
- issue_rd  in  ADDRW  destination index.
- issue_rd_wen  in  1  instruction writes rd.
- wb_valid  in  1  writeback result present, always accepted.
- wb_rd  in  ADDRW  writeback index.
- wb_data  in  DATAW  writeback value.
- rf_addr_rs1, rf_addr_rs2  out  ADDRW  register-file read addresses.
- rf_write_enable  out  1  register-file write strobe.
- rf_addr_rd  out  ADDRW  register-file write address.
- rf_data_rd  out  DATAW  register-file write data.
- operand_valid  out  1  register-file read data valid this cycle.
- outstanding  out  ADDRW+1  count of busy registers.
- wb_error  out  1  sticky writeback-to-idle-register flag.

Function
REQ-003 Per-register busy bit SHALL exist for indices 1..NUM_REGS-1; x0 SHALL never be busy.
REQ-004 issue_ready SHALL be combinational: low if (issue_use_rs1 && busy[issue_rs1]) or (issue_use_rs2 && busy[issue_rs2]) or (issue_rd_wen && busy[issue_rd]); otherwise high.
REQ-005 Hazard check SHALL use registered busy state only; a same-cycle writeback SHALL NOT unblock issue, because the register file returns old data on a same-edge read-during-write.
REQ-006 rf_addr_rs1/rf_addr_rs2 SHALL pass issue_rs1/issue_rs2 combinationally.
REQ-007 operand_valid SHALL assert exactly one cycle after an accepted issue, matching the register file's one-cycle read latency; it SHALL be 0 otherwise.
REQ-008 Accepted issue with issue_rd_wen=1 and issue_rd!=0 SHALL set busy[issue_rd] at the next edge.
REQ-009 wb_valid with wb_rd!=0 SHALL drive rf_write_enable=1, rf_addr_rd=wb_rd and rf_data_rd=wb_data combinationally, and SHALL clear busy[wb_rd] at the next edge.
REQ-010 wb_valid with wb_rd=0 SHALL force rf_write_enable=0 and leave state unchanged.
REQ-011 If the same register is set and cleared in one cycle, set SHALL win.
REQ-012 wb_valid to a non-busy nonzero register SHALL still write the register file and SHALL set wb_error, which holds until reset.
REQ-013 outstanding SHALL equal the population count of busy, updated registered, and range 0..NUM_REGS-1 with no wrap.
REQ-014 At most one issue and one writeback SHALL be processed per cycle.

Reset
REQ-015 While reset=1 at an edge: busy SHALL be cleared to all 0, outstanding=0, operand_valid=0, wb_error=0; issue and wb inputs SHALL be ignored and rf_write_enable=0.
REQ-016 Reset mid-operation SHALL drop all pending destinations; a later writeback for a dropped destination SHALL raise wb_error per REQ-012.
REQ-017 Register-file contents SHALL NOT be reset by this block.

Structure
REQ-018 DATAW, NUM_REGS, ADDRW and constant REG_ZERO=0 SHALL live in shared package regfile_pkg.
REQ-019 The block SHALL be a single module with no sub-module; the busy vector and popcount are inline.
REQ-020 The block SHALL have no combinational path from wb_* to issue_ready.

Verification
REQ-021 Issue rd=5 wen; next cycle issue rs1=5 -> issue_ready=0 until the cycle after wb_rd=5; outstanding 1 -> 0.
REQ-022 Issue rs1=5 in the same cycle wb_rd=5 arrives -> issue_ready=0 that cycle, 1 the next cycle; operand_valid high one cycle after acceptance.
REQ-023 wb_valid wb_rd=0 wb_data=32'hDEADBEEF -> rf_write_enable=0, wb_error stays 0; issue rd=0 wen -> outstanding stays 0, no stall.
REQ-024 Issue rd=1..31 back-to-back with no writebacks -> outstanding reaches 31; issue rs1=31 stalls; wb_rd=31 -> outstanding=30.
REQ-025 Reset with rd=7 busy, then wb_rd=7 -> busy clear, rf_write_enable=1, wb_error=1 sticky until the next reset.
REQ-026 Same-cycle issue rd=9 and wb_rd=9 with 9 not busy -> busy[9]=1 after the edge, wb_error=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and constants for the register-file scoreboard.
package regfile_pkg;

    localparam int DATAW    = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDRW    = $clog2(NUM_REGS);
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Register busy-bit scoreboard: stalls issue on RAW/WAW hazards and
// forwards writebacks to the register-file write port.
module regfile_scoreboard #(
    parameter int DATAW    = regfile_pkg::DATAW,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDRW    = $clog2(NUM_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [ADDRW-1:0] issue_rs1,
    input  logic [ADDRW-1:0] issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  logic [ADDRW-1:0] issue_rd,
    input  logic             issue_rd_wen,
    input  logic             wb_valid,
    input  logic [ADDRW-1:0] wb_rd,
    input  logic [DATAW-1:0] wb_data,
    output logic [ADDRW-1:0] rf_addr_rs1,
    output logic [ADDRW-1:0] rf_addr_rs2,
    output logic             rf_write_enable,
    output logic [ADDRW-1:0] rf_addr_rd,
    output logic [DATAW-1:0] rf_data_rd,
    output logic             operand_valid,
    output logic [ADDRW:0]   outstanding,
    output logic             wb_error
);

    localparam logic [ADDRW-1:0] ZERO = ADDRW'(regfile_pkg::REG_ZERO);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [ADDRW:0]      count_next;
    logic                fire;
    logic                wb_live;
    logic                wb_idle;

    // Only registered busy feeds the hazard check; no wb_* path here.
    assign issue_ready = !((issue_use_rs1 && busy[issue_rs1]) ||
                           (issue_use_rs2 && busy[issue_rs2]) ||
                           (issue_rd_wen  && busy[issue_rd]));

    assign fire    = issue_valid && issue_ready;
    assign wb_live = wb_valid && (wb_rd != ZERO);
    assign wb_idle = wb_live && !busy[wb_rd];

    assign rf_addr_rs1     = issue_rs1;
    assign rf_addr_rs2     = issue_rs2;
    assign rf_write_enable = wb_live && !reset;
    assign rf_addr_rd      = wb_rd;
    assign rf_data_rd      = wb_data;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (fire && issue_rd_wen && (issue_rd != ZERO)) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (wb_live) begin
            clr_vec[wb_rd] = 1'b1;
        end
        // Set wins over a same-cycle clear of the same register.
        busy_next    = (busy & ~clr_vec) | set_vec;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        count_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            count_next = count_next + {{ADDRW{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy          <= '0;
            outstanding   <= '0;
            operand_valid <= 1'b0;
            wb_error      <= 1'b0;
        end else begin
            busy          <= busy_next;
            outstanding   <= count_next;
            operand_valid <= fire;
            wb_error      <= wb_error || wb_idle;
        end
    end

endmodule
